lw_sha_dma_master: RTL and testbench

- AXI4 burst master that feeds message words into the SHA slave's DIN register and drains the digest from its HASH registers, paced by the slave's dma_wr_req / dma_rd_req outputs.
- Sits directly upstream of the SHA AXI4 slave top, between a system data stream and that slave.
- Write data is held in a commit/rewind FIFO, so bursts the slave rejects with SLVERR are replayed, not lost.

---
 rtl/lw_sha_dma_pkg.sv | 29 ++
 rtl/lw_sha_dma_fifo.sv | 85 ++++++++
 rtl/lw_sha_dma_master.sv | 224 ++++++++++++++++++++++
 tb/tb_lw_sha_dma_master.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lw_sha_dma_pkg.sv
// Shared constants and state types for the SHA DMA burst master.
package lw_sha_dma_pkg;

  localparam int BUS_WIDTH = 32;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [11:0] DIN_ADDR  = 12'h010;
  localparam logic [11:0] HASH_ADDR = 12'h020;

  typedef enum logic [1:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA
  } r_state_e;

endpackage

// File: rtl/lw_sha_dma_fifo.sv
// Commit/rewind FIFO: words are popped speculatively into a burst and only
// released for good once the burst is acknowledged, so rejected bursts replay.
module lw_sha_dma_fifo #(
  parameter int D_WIDTH   = 32,
  parameter int BURST_LEN = 4,
  parameter int PTR_W     = $clog2(2 * BURST_LEN) + 1,
  parameter int CNT_W     = $clog2(BURST_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               push_last,
  input  logic               pop_spec,
  input  logic               commit,
  input  logic               rewind,
  output logic               full,
  output logic [PTR_W-1:0]   spec_count,
  output logic [D_WIDTH-1:0] head_data,
  output logic               tlast_found,
  output logic [CNT_W-1:0]   tlast_off
);
  import lw_sha_dma_pkg::*;

  localparam int DEPTH = 2 * BURST_LEN;
  localparam int AW    = PTR_W - 1;

  logic [D_WIDTH:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d;
  logic [PTR_W-1:0]   rd_spec_q, rd_spec_d;
  logic [PTR_W-1:0]   rd_commit_q, rd_commit_d;
  logic [PTR_W-1:0]   used;
  logic [PTR_W-1:0]   idx;

  // Occupancy is measured against the commit pointer so space held by an
  // unacknowledged burst is never overwritten.
  assign used       = wr_q - rd_commit_q;
  assign full       = (used == PTR_W'(DEPTH));
  assign spec_count = wr_q - rd_spec_q;
  assign head_data  = mem_q[rd_spec_q[AW-1:0]][D_WIDTH-1:0];

  // Pointer updates: push, speculative pop, commit and rewind.
  always_comb begin
    wr_d        = wr_q;
    rd_spec_d   = rd_spec_q;
    rd_commit_d = rd_commit_q;
    if (push && !full) wr_d = wr_q + PTR_W'(1);
    if (rewind) rd_spec_d = rd_commit_q;
    else if (pop_spec) rd_spec_d = rd_spec_q + PTR_W'(1);
    if (commit) rd_commit_d = rd_spec_q;
  end

  // Find the first tlast among the next BURST_LEN unsent words; lowest wins.
  always_comb begin
    tlast_found = 1'b0;
    tlast_off   = '0;
    idx         = '0;
    for (int i = BURST_LEN - 1; i >= 0; i--) begin
      idx = rd_spec_q + PTR_W'(i);
      if ((PTR_W'(i) < spec_count) && mem_q[idx[AW-1:0]][D_WIDTH]) begin
        tlast_found = 1'b1;
        tlast_off   = CNT_W'(i);
      end
    end
  end

  // Storage array; contents are meaningless once pointers are reset.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_q[AW-1:0]] <= {push_last, push_data};
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_spec_q   <= '0;
      rd_commit_q <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_spec_q   <= rd_spec_d;
      rd_commit_q <= rd_commit_d;
    end
  end

endmodule

// File: rtl/lw_sha_dma_master.sv
// AXI4 burst master feeding the SHA slave DIN register from a stream and
// draining the digest HASH registers to an output stream.
module lw_sha_dma_master #(
  parameter int          D_WIDTH    = lw_sha_dma_pkg::BUS_WIDTH,
  parameter int          BURST_LEN  = 4,
  parameter int          HASH_BEATS = 256 / D_WIDTH,
  parameter logic [11:0] DIN_ADDR   = lw_sha_dma_pkg::DIN_ADDR,
  parameter logic [11:0] HASH_ADDR  = lw_sha_dma_pkg::HASH_ADDR
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [D_WIDTH-1:0] s_tdata,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  output logic               s_tready,
  output logic [D_WIDTH-1:0] m_tdata,
  output logic               m_tvalid,
  output logic               m_tlast,
  input  logic               m_tready,
  input  logic               dma_wr_req_i,
  input  logic               dma_rd_req_i,
  output logic [11:0]        awaddr,
  output logic [7:0]         awlen,
  output logic [2:0]         awsize,
  output logic [1:0]         awburst,
  output logic [3:0]         awid,
  output logic               awvalid,
  input  logic               awready,
  output logic [D_WIDTH-1:0] wdata,
  output logic               wlast,
  output logic               wvalid,
  input  logic               wready,
  input  logic [1:0]         bresp,
  input  logic               bvalid,
  output logic               bready,
  output logic [11:0]        araddr,
  output logic [7:0]         arlen,
  output logic [2:0]         arsize,
  output logic [1:0]         arburst,
  output logic               arvalid,
  input  logic               arready,
  input  logic [D_WIDTH-1:0] rdata,
  input  logic [1:0]         rresp,
  input  logic               rlast,
  input  logic               rvalid,
  output logic               rready,
  output logic               err_o,
  input  logic               err_clr_i,
  output logic               busy_o
);
  import lw_sha_dma_pkg::*;

  localparam int         PTR_W = $clog2(2 * BURST_LEN) + 1;
  localparam int         CNT_W = $clog2(BURST_LEN) + 1;
  localparam logic [2:0] AXSIZE = 3'($clog2(D_WIDTH / 8));

  w_state_e         w_state_q, w_state_d;
  r_state_e         r_state_q, r_state_d;
  logic [CNT_W-1:0] burst_last_q, burst_last_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic [11:0]      awaddr_q, awaddr_d;
  logic             err_q, err_d;
  logic             rd_req_q, rd_req_d;
  logic             rd_pend_q, rd_pend_d;
  logic             rd_edge, wr_err, rd_err, beat_last;

  logic             fifo_push, fifo_pop, fifo_commit, fifo_rewind, fifo_full;
  logic [PTR_W-1:0] spec_count;
  logic [D_WIDTH-1:0] head_data;
  logic             tlast_found;
  logic [CNT_W-1:0] tlast_off;

  assign s_tready  = !fifo_full;
  assign fifo_push = s_tvalid && !fifo_full;

  lw_sha_dma_fifo #(
    .D_WIDTH  (D_WIDTH),
    .BURST_LEN(BURST_LEN),
    .PTR_W    (PTR_W),
    .CNT_W    (CNT_W)
  ) u_fifo (
    .clk        (aclk),
    .rst_n      (aresetn),
    .push       (fifo_push),
    .push_data  (s_tdata),
    .push_last  (s_tlast),
    .pop_spec   (fifo_pop),
    .commit     (fifo_commit),
    .rewind     (fifo_rewind),
    .full       (fifo_full),
    .spec_count (spec_count),
    .head_data  (head_data),
    .tlast_found(tlast_found),
    .tlast_off  (tlast_off)
  );

  assign beat_last = (beat_q == burst_last_q);

  assign awaddr  = awaddr_q;
  assign awlen   = 8'(burst_last_q);
  assign awsize  = AXSIZE;
  assign awburst = AXI_BURST_FIXED;
  assign awid    = 4'd0;
  assign awvalid = (w_state_q == W_ADDR);
  assign wvalid  = (w_state_q == W_DATA);
  assign wlast   = (w_state_q == W_DATA) && beat_last;
  assign wdata   = head_data;
  assign bready  = (w_state_q == W_RESP);

  assign araddr  = HASH_ADDR;
  assign arlen   = 8'(HASH_BEATS - 1);
  assign arsize  = AXSIZE;
  assign arburst = AXI_BURST_INCR;
  assign arvalid = (r_state_q == R_ADDR);
  assign rready  = (r_state_q == R_DATA) && m_tready;
  assign m_tvalid = (r_state_q == R_DATA) && rvalid;
  assign m_tlast  = (r_state_q == R_DATA) && rlast;
  assign m_tdata  = rdata;

  assign err_o  = err_q;
  assign busy_o = (w_state_q != W_IDLE) || (r_state_q != R_IDLE);

  // Write channel: size a burst, issue AW, stream beats, then commit or rewind.
  always_comb begin
    w_state_d    = w_state_q;
    burst_last_d = burst_last_q;
    beat_d       = beat_q;
    awaddr_d     = awaddr_q;
    fifo_pop     = 1'b0;
    fifo_commit  = 1'b0;
    fifo_rewind  = 1'b0;
    wr_err       = 1'b0;
    unique case (w_state_q)
      W_IDLE: begin
        if (dma_wr_req_i && ((spec_count >= PTR_W'(BURST_LEN)) || tlast_found)) begin
          burst_last_d = tlast_found ? tlast_off : CNT_W'(BURST_LEN - 1);
          awaddr_d     = DIN_ADDR;
          beat_d       = '0;
          w_state_d    = W_ADDR;
        end
      end
      W_ADDR: begin
        if (awready) w_state_d = W_DATA;
      end
      W_DATA: begin
        if (wready) begin
          fifo_pop = 1'b1;
          beat_d   = beat_q + CNT_W'(1);
          if (beat_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          if (bresp == AXI_RESP_OKAY) begin
            fifo_commit = 1'b1;
          end else begin
            fifo_rewind = 1'b1;
            wr_err      = 1'b1;
          end
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: one digest burst per latched rising edge of the request.
  always_comb begin
    rd_req_d  = dma_rd_req_i;
    rd_edge   = dma_rd_req_i && !rd_req_q;
    r_state_d = r_state_q;
    rd_pend_d = rd_pend_q || rd_edge;
    rd_err    = 1'b0;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_pend_q) begin
          r_state_d = R_ADDR;
          rd_pend_d = rd_edge;
        end
      end
      R_ADDR: begin
        if (arready) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (rvalid && m_tready) begin
          if (rresp != AXI_RESP_OKAY) rd_err = 1'b1;
          if (rlast) r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (err_clr_i) err_d = 1'b0;
    if (wr_err || rd_err) err_d = 1'b1;
  end

  // State registers for both channels and the error flag.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      burst_last_q <= '0;
      beat_q       <= '0;
      awaddr_q     <= '0;
      err_q        <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      burst_last_q <= burst_last_d;
      beat_q       <= beat_d;
      awaddr_q     <= awaddr_d;
      err_q        <= err_d;
      rd_req_q     <= rd_req_d;
      rd_pend_q    <= rd_pend_d;
    end
  end

endmodule

// File: tb/tb_lw_sha_dma_master.sv
// Randomized bench for lw_sha_dma_master: a queue model of pushed words
// predicts every burst and beat; a reactive AXI slave checks them.
module tb_lw_sha_dma_master;
  import lw_sha_dma_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic        dma_wr_req_i = 1'b0, dma_rd_req_i = 1'b0;
  logic [11:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst;
  logic [3:0]  awid;
  logic        awvalid, wvalid, wlast, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic [31:0] wdata;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = 2'b00;
  logic        err_o, busy_o;
  logic        err_clr_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  word_t      modelQ[$];
  logic [1:0] respPlan[$];
  int         awCount = 0, okCount = 0, bErrCount = 0;
  int         beatIdx = 0, burstN = 0;
  bit         stallSecond = 1'b0;
  bit         respPending = 1'b0;
  logic [1:0] respVal = 2'b00;

  lw_sha_dma_master #(.D_WIDTH(32), .BURST_LEN(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .dma_wr_req_i(dma_wr_req_i), .dma_rd_req_i(dma_rd_req_i),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awid(awid),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_o(err_o), .err_clr_i(err_clr_i), .busy_o(busy_o)
  );

  // Free-running clock.
  always #5 aclk = ~aclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Burst length the model predicts from the unacknowledged word queue.
  function automatic int expectedBurstLen();
    int n = 0;
    for (int i = 0; i < 4 && i < modelQ.size(); i++) begin
      n = i + 1;
      if (modelQ[i].last) break;
    end
    return n;
  endfunction

  // Push one stream word after a random gap; the model records it on acceptance.
  task automatic applyStimulus(input logic [31:0] data, input logic last);
    int t = 0;
    @(posedge aclk); #1;
    repeat ($urandom_range(0, 2)) begin @(posedge aclk); #1; end
    s_tvalid = 1'b1;
    s_tdata  = data;
    s_tlast  = last;
    forever begin
      @(negedge aclk);
      if (s_tready) begin
        modelQ.push_back(word_t'{data, last});
        break;
      end
      t++;
      if (t > 300) begin
        checkOutput("push_timeout", 32'(s_tready), 32'd1);
        break;
      end
      @(posedge aclk); #1;
    end
    @(posedge aclk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic sendMessage(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) applyStimulus(base + 32'(i), i == n - 1);
  endtask

  task automatic waitDrain();
    int t = 0;
    do begin @(negedge aclk); t++; end
    while ((modelQ.size() != 0 || busy_o) && t < 2000);
    checkOutput("drain_done", 32'(modelQ.size() == 0 && !busy_o), 32'd1);
  endtask

  task automatic clearError();
    @(posedge aclk); #1; err_clr_i = 1'b1;
    @(posedge aclk); #1; err_clr_i = 1'b0;
    @(negedge aclk);
    checkOutput("err_cleared", 32'(err_o), 32'd0);
  endtask

  // Reactive AXI write slave: observe handshakes mid-cycle, drive just after the edge.
  always begin
    @(negedge aclk);
    if (!aresetn) begin
      beatIdx     = 0;
      respPending = 1'b0;
    end else begin
      if (awvalid && awready) begin
        burstN = expectedBurstLen();
        checkOutput("awlen", 32'(awlen), 32'(burstN - 1));
        checkOutput("awaddr", 32'(awaddr), 32'(DIN_ADDR));
        checkOutput("awburst", 32'(awburst), 32'(AXI_BURST_FIXED));
        checkOutput("awsize", 32'(awsize), 32'd2);
        checkOutput("awid", 32'(awid), 32'd0);
        awCount++;
        beatIdx = 0;
      end
      if (wvalid && wready) begin
        checkOutput("wbeat_in_range", 32'(beatIdx < modelQ.size()), 32'd1);
        if (beatIdx < modelQ.size()) checkOutput("wdata", wdata, modelQ[beatIdx].data);
        checkOutput("wlast", 32'(wlast), 32'(beatIdx == burstN - 1));
        beatIdx++;
        if (wlast) begin
          respPending = 1'b1;
          respVal = (respPlan.size() != 0) ? respPlan.pop_front() : AXI_RESP_OKAY;
        end
      end
      if (bvalid && bready) begin
        if (bresp == AXI_RESP_OKAY) begin
          repeat (burstN) if (modelQ.size() != 0) void'(modelQ.pop_front());
          okCount++;
        end else begin
          bErrCount++;
        end
        respPending = 1'b0;
      end
    end
    @(posedge aclk); #1;
    awready = 1'($urandom_range(0, 1));
    wready  = (stallSecond && beatIdx >= 1) ? 1'b0 : 1'($urandom_range(0, 1));
    bvalid  = respPending && (bvalid || 1'($urandom_range(0, 1)));
    bresp   = respVal;
  end

  // Digest read: AR checks, then 8 beats with a 5-cycle consumer stall on beat 3.
  task automatic readDigest(input int errBeat);
    logic [31:0] exp [8];
    int t = 0;
    int stall;
    for (int k = 0; k < 8; k++) exp[k] = $urandom;
    @(posedge aclk); #1; dma_rd_req_i = 1'b1;
    do begin @(negedge aclk); t++; end while (!arvalid && t < 50);
    checkOutput("arvalid", 32'(arvalid), 32'd1);
    checkOutput("araddr", 32'(araddr), 32'(HASH_ADDR));
    checkOutput("arlen", 32'(arlen), 32'd7);
    checkOutput("arburst", 32'(arburst), 32'(AXI_BURST_INCR));
    checkOutput("arsize", 32'(arsize), 32'd2);
    @(posedge aclk); #1; arready = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1; arready = 1'b0; dma_rd_req_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rvalid    = 1'b1;
      rdata     = exp[k];
      rlast     = (k == 7);
      rresp     = (k == errBeat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      err_clr_i = (k == errBeat);
      stall     = (k == 2) ? 5 : $urandom_range(0, 1);
      m_tready  = 1'b0;
      repeat (stall) begin
        @(negedge aclk);
        checkOutput("rready_stall", 32'(rready), 32'd0);
        checkOutput("m_tvalid_stall", 32'(m_tvalid), 32'd1);
        @(posedge aclk); #1;
      end
      m_tready = 1'b1;
      @(negedge aclk);
      checkOutput("m_tvalid", 32'(m_tvalid), 32'd1);
      checkOutput("rready", 32'(rready), 32'd1);
      checkOutput("m_tdata", m_tdata, exp[k]);
      checkOutput("m_tlast", 32'(m_tlast), 32'(k == 7));
      @(posedge aclk); #1;
    end
    rvalid = 1'b0; rlast = 1'b0; m_tready = 1'b0; err_clr_i = 1'b0; rresp = AXI_RESP_OKAY;
    @(negedge aclk);
    checkOutput("rd_busy_done", 32'(busy_o), 32'd0);
    checkOutput("rd_err", 32'(err_o), 32'(errBeat >= 0));
  endtask

  // Hard time limit so the bench always terminates.
  initial begin
    #900000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence.
  initial begin
    int base;
    int t;
    #3;
    checkOutput("rst_s_tready", 32'(s_tready), 32'd1);
    checkOutput("rst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("rst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("rst_wlast", 32'(wlast), 32'd0);
    checkOutput("rst_bready", 32'(bready), 32'd0);
    checkOutput("rst_arvalid", 32'(arvalid), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_err", 32'(err_o), 32'd0);
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;

    $display("[TB] two full bursts of 8 words");
    @(posedge aclk); #1; dma_wr_req_i = 1'b1;
    base = awCount;
    sendMessage(8, 32'h1);
    waitDrain();
    checkOutput("two_bursts", 32'(awCount - base), 32'd2);

    $display("[TB] short 3-word message");
    base = awCount;
    sendMessage(3, 32'h100);
    waitDrain();
    repeat (10) @(negedge aclk);
    checkOutput("short_one_burst", 32'(awCount - base), 32'd1);
    checkOutput("short_empty", 32'(s_tready), 32'd1);

    $display("[TB] SLVERR replay");
    respPlan.push_back(AXI_RESP_SLVERR);
    base = awCount;
    sendMessage(4, 32'h11);
    waitDrain();
    checkOutput("replay_bursts", 32'(awCount - base), 32'd2);
    checkOutput("slverr_sticky", 32'(err_o), 32'd1);
    clearError();

    $display("[TB] full FIFO with request low, then DECERR on first burst");
    @(posedge aclk); #1; dma_wr_req_i = 1'b0;
    base = awCount;
    sendMessage(8, 32'h200);
    @(negedge aclk);
    checkOutput("full_s_tready", 32'(s_tready), 32'd0);
    repeat (10) @(negedge aclk);
    checkOutput("full_no_aw", 32'(awCount - base), 32'd0);
    checkOutput("full_awvalid", 32'(awvalid), 32'd0);
    checkOutput("full_busy", 32'(busy_o), 32'd0);
    respPlan.push_back(AXI_RESP_DECERR);
    base = bErrCount;
    @(posedge aclk); #1; dma_wr_req_i = 1'b1;
    t = 0;
    do begin @(negedge aclk); t++; end while (bErrCount == base && t < 500);
    @(negedge aclk);
    checkOutput("rewound_still_full", 32'(s_tready), 32'd0);
    checkOutput("decerr_sticky", 32'(err_o), 32'd1);
    base = okCount;
    t = 0;
    do begin @(negedge aclk); t++; end while (okCount == base && t < 500);
    @(negedge aclk);
    checkOutput("commit_frees", 32'(s_tready), 32'd1);
    waitDrain();
    clearError();

    $display("[TB] reset during second write beat");
    stallSecond = 1'b1;
    sendMessage(8, 32'h300);
    t = 0;
    do begin @(negedge aclk); t++; end while (!(beatIdx == 1 && wvalid) && t < 500);
    @(negedge aclk);
    checkOutput("pre_rst_wvalid", 32'(wvalid), 32'd1);
    checkOutput("pre_rst_full", 32'(s_tready), 32'd0);
    #2 aresetn = 1'b0;
    #1;
    checkOutput("arst_wvalid", 32'(wvalid), 32'd0);
    checkOutput("arst_awvalid", 32'(awvalid), 32'd0);
    checkOutput("arst_s_tready", 32'(s_tready), 32'd1);
    checkOutput("arst_busy", 32'(busy_o), 32'd0);
    modelQ.delete();
    respPlan.delete();
    stallSecond = 1'b0;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1'b1;
    base = awCount;
    sendMessage(3, 32'hA1);
    waitDrain();
    checkOutput("post_rst_burst", 32'(awCount - base), 32'd1);

    $display("[TB] digest reads");
    @(posedge aclk); #1; dma_wr_req_i = 1'b0;
    readDigest(-1);
    readDigest(3);
    clearError();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
